// File: rtl/adder_bist_checker.sv
// adder_bist_checker
//   Built-in self-test engine for a WIDTH-bit combinational adder. It sweeps
//   every operand pair (op_a, op_b) in ascending order of the concatenated
//   vector {op_a, op_b}. Each pair is held for SETTLE cycles, then the
//   adder's {carry, sum} is checked against op_a + op_b for one cycle.
//   The engine counts mismatches (saturating) and reports done and pass.
//
// Parameters
//   WIDTH  : operand width (1 = half adder)
//   SETTLE : cycles each vector is held before its check, 1..15
//   ERR_W  : width of the saturating error counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle run request, honoured only in IDLE or DONE
//   op_a/op_b  registered operands driven to the adder under test
//   dut_sum    sum returned by the adder under test
//   dut_carry  carry-out returned by the adder under test
//   busy       high while a sweep is in progress
//   done       high once the sweep has finished
//   pass       high in DONE when no mismatch was seen
//   err_count  number of mismatching vectors, saturating at all-ones
//
// Build option
//   ADDER_BIST_STOP_ON_FAIL_EN : when defined, the first mismatch ends the
//   sweep. The operands stay frozen at the failing vector.

module adder_bist_checker #(
   parameter int WIDTH  = 1,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] dut_sum,
   input  logic             dut_carry,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count
);

   localparam int            VW          = 2 * WIDTH;
   localparam logic [VW-1:0] V_LAST      = '1;
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_CHECK,
      ST_DONE
   } state_t;

   state_t           state;
   logic [VW-1:0]    vec;
   logic [3:0]       settle_cnt;
   logic [WIDTH:0]   expected;
   logic             mismatch;
   logic             stop_now;
   logic [ERR_W-1:0] err_next;

   // The operands are slices of the registered vector index. They therefore
   // come straight from flops, and they hold the last vector once in DONE.
   assign op_a = vec[VW-1:WIDTH];
   assign op_b = vec[WIDTH-1:0];

   always_comb begin
      expected = {1'b0, op_a} + {1'b0, op_b};
      mismatch = ({dut_carry, dut_sum} != expected);
      err_next = err_count;
      if (mismatch && (err_count != '1)) begin
         err_next = err_count + ERR_W'(1);
      end
   end

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
   assign stop_now = mismatch;
`else
   assign stop_now = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_APPLY;
                  vec        <= '0;
                  settle_cnt <= '0;
                  err_count  <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            ST_APPLY: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_CHECK: begin
               err_count <= err_next;
               // Exit on the last vector (or on the first failure when that
               // option is built in). vec never wraps back to 0 mid-run.
               if ((vec == V_LAST) || stop_now) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  vec   <= vec + VW'(1);
                  state <= ST_APPLY;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_bist_checker.sv
// Self-checking bench for adder_bist_checker.
// Three instances are used: WIDTH=1/SETTLE=1/ERR_W=8, WIDTH=1/SETTLE=1/ERR_W=2
// and WIDTH=2/SETTLE=3/ERR_W=8. Each instance drives a behavioural adder
// whose fault mode the bench selects:
//   mode 0 : correct adder
//   mode 1 : carry stuck at 0
//   mode 2 : all outputs inverted
//   mode 3 : sum LSB flipped on a random set of vectors

module tb_adder_bist_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic start_s [3];

   int       mode_r [3];
   bit [15:0] bad_r [3];
   int       w_of [3] = '{1, 1, 2};
   int       s_of [3] = '{1, 1, 3};
   int       e_of [3] = '{8, 2, 8};

   int nchk = 0;
   int nerr = 0;

   logic       a0, b0, s0, c0, busy0, done0, pass0;
   logic [7:0] err0;
   logic       a1, b1, s1, c1, busy1, done1, pass1;
   logic [1:0] err1;
   logic [1:0] a2, b2, s2;
   logic       c2, busy2, done2, pass2;
   logic [7:0] err2;

   always #5 clk = ~clk;

   // Adder under test: correct sum with an optional fault applied.
   function automatic int faulty(int w, int a, int b, int mode, bit badv);
      int r;
      int mask;
      r    = a + b;
      mask = (1 << (w + 1)) - 1;
      case (mode)
         1:       r = r & ((1 << w) - 1);
         2:       r = (~r) & mask;
         3:       if (badv) r = r ^ 1;
         default: ;
      endcase
      return r;
   endfunction

   always_comb begin
      int r;
      r = faulty(1, int'(a0), int'(b0), mode_r[0], bad_r[0][int'(a0) * 2 + int'(b0)]);
      {c0, s0} = 2'(r);
   end
   always_comb begin
      int r;
      r = faulty(1, int'(a1), int'(b1), mode_r[1], bad_r[1][int'(a1) * 2 + int'(b1)]);
      {c1, s1} = 2'(r);
   end
   always_comb begin
      int r;
      r = faulty(2, int'(a2), int'(b2), mode_r[2], bad_r[2][int'(a2) * 4 + int'(b2)]);
      {c2, s2} = 3'(r);
   end

   adder_bist_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op_a(a0), .op_b(b0),
      .dut_sum(s0), .dut_carry(c0), .busy(busy0), .done(done0), .pass(pass0),
      .err_count(err0));
   adder_bist_checker #(.WIDTH(1), .SETTLE(1), .ERR_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op_a(a1), .op_b(b1),
      .dut_sum(s1), .dut_carry(c1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1));
   adder_bist_checker #(.WIDTH(2), .SETTLE(3), .ERR_W(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start_s[2]), .op_a(a2), .op_b(b2),
      .dut_sum(s2), .dut_carry(c2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err2));

   function automatic int get_busy(int k);
      case (k)
         0: return int'(busy0);
         1: return int'(busy1);
         default: return int'(busy2);
      endcase
   endfunction
   function automatic int get_done(int k);
      case (k)
         0: return int'(done0);
         1: return int'(done1);
         default: return int'(done2);
      endcase
   endfunction
   function automatic int get_pass(int k);
      case (k)
         0: return int'(pass0);
         1: return int'(pass1);
         default: return int'(pass2);
      endcase
   endfunction
   function automatic int get_err(int k);
      case (k)
         0: return int'(err0);
         1: return int'(err1);
         default: return int'(err2);
      endcase
   endfunction
   function automatic int get_a(int k);
      case (k)
         0: return int'(a0);
         1: return int'(a1);
         default: return int'(a2);
      endcase
   endfunction
   function automatic int get_b(int k);
      case (k)
         0: return int'(b0);
         1: return int'(b1);
         default: return int'(b2);
      endcase
   endfunction

   task automatic check(input string name, input int k, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s (inst %0d): got %0d, expected %0d", name, k, act, exp);
      end
   endtask

   // Reference model: sweep all operand pairs and count the vectors where
   // the faulty adder differs from plain a+b.
   task automatic model(input int k, output int e_err, output bit e_pass,
                        output int e_cyc, output int e_a, output int e_b);
      int n;
      int cnt;
      int first;
      int w;
      int maxerr;
      w      = w_of[k];
      n      = 1 << (2 * w);
      cnt    = 0;
      first  = -1;
      maxerr = (1 << e_of[k]) - 1;
      for (int v = 0; v < n; v++) begin
         int a;
         int b;
         a = v >> w;
         b = v & ((1 << w) - 1);
         if (faulty(w, a, b, mode_r[k], bad_r[k][v]) != a + b) begin
            cnt++;
            if (first < 0) first = v;
         end
      end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
      if (first >= 0) begin
         e_err = 1;
         e_cyc = (first + 1) * (s_of[k] + 1);
         e_a   = first >> w;
         e_b   = first & ((1 << w) - 1);
      end else begin
         e_err = 0;
         e_cyc = n * (s_of[k] + 1);
         e_a   = (1 << w) - 1;
         e_b   = (1 << w) - 1;
      end
`else
      e_err = (cnt > maxerr) ? maxerr : cnt;
      e_cyc = n * (s_of[k] + 1);
      e_a   = (1 << w) - 1;
      e_b   = (1 << w) - 1;
`endif
      e_pass = (e_err == 0);
   endtask

   task automatic run(input int k, input int e_err, input bit e_pass, input int e_cyc,
                      input int e_a, input int e_b, input bit poke);
      int cyc;
      bit busy_ok;
      @(negedge clk);
      start_s[k] = 1'b1;
      @(posedge clk);
      #1;
      start_s[k] = 1'b0;
      check("start_done_clr", k, get_done(k), 0);
      check("start_pass_clr", k, get_pass(k), 0);
      check("start_err_clr", k, get_err(k), 0);
      check("start_busy", k, get_busy(k), 1);
      check("start_op_a", k, get_a(k), 0);
      check("start_op_b", k, get_b(k), 0);
      cyc     = 0;
      busy_ok = 1'b1;
      while (get_done(k) == 0 && cyc < 2000) begin
         if (get_busy(k) != 1) busy_ok = 1'b0;
         start_s[k] = (poke && cyc == 3);
         @(posedge clk);
         #1;
         cyc++;
      end
      start_s[k] = 1'b0;
      check("busy_during_run", k, int'(busy_ok), 1);
      check("done_latency", k, cyc, e_cyc);
      check("busy_in_done", k, get_busy(k), 0);
      check("err_count", k, get_err(k), e_err);
      check("pass", k, get_pass(k), int'(e_pass));
      check("op_a_final", k, get_a(k), e_a);
      check("op_b_final", k, get_b(k), e_b);
      @(posedge clk);
      #1;
      check("done_held", k, get_done(k), 1);
      check("op_a_held", k, get_a(k), e_a);
      check("op_b_held", k, get_b(k), e_b);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 3; k++) begin
         check({tag, "_busy"}, k, get_busy(k), 0);
         check({tag, "_done"}, k, get_done(k), 0);
         check({tag, "_pass"}, k, get_pass(k), 0);
         check({tag, "_err"}, k, get_err(k), 0);
         check({tag, "_op_a"}, k, get_a(k), 0);
         check({tag, "_op_b"}, k, get_b(k), 0);
      end
   endtask

   typedef struct {
      int inst;
      int mode;
      int err;
      bit pass;
      int cyc;
      int a;
      int b;
      bit poke;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int e_err;
      bit e_pass;
      int e_cyc;
      int e_a;
      int e_b;
      int k;

      tbl[0] = '{0, 0, 0, 1'b1, 8, 1, 1, 1'b0};
      tbl[1] = '{0, 1, 1, 1'b0, 8, 1, 1, 1'b0};
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
      tbl[2] = '{1, 2, 1, 1'b0, 2, 0, 0, 1'b0};
      tbl[3] = '{2, 0, 0, 1'b1, 64, 3, 3, 1'b1};
      tbl[4] = '{2, 1, 1, 1'b0, 32, 1, 3, 1'b0};
      tbl[5] = '{0, 2, 1, 1'b0, 2, 0, 0, 1'b0};
`else
      tbl[2] = '{1, 2, 3, 1'b0, 8, 1, 1, 1'b0};
      tbl[3] = '{2, 0, 0, 1'b1, 64, 3, 3, 1'b1};
      tbl[4] = '{2, 1, 6, 1'b0, 64, 3, 3, 1'b0};
      tbl[5] = '{0, 2, 4, 1'b0, 8, 1, 1, 1'b0};
`endif

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         mode_r[i]  = 0;
         bad_r[i]   = '0;
      end
      #12;
      check_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_no_activity", 2, get_busy(2), 0);

      for (int i = 0; i < 6; i++) begin
         mode_r[tbl[i].inst] = tbl[i].mode;
         bad_r[tbl[i].inst]  = '0;
         run(tbl[i].inst, tbl[i].err, tbl[i].pass, tbl[i].cyc, tbl[i].a, tbl[i].b, tbl[i].poke);
      end

      for (int r = 0; r < 8; r++) begin
         k         = int'($urandom_range(0, 2));
         mode_r[k] = 3;
         bad_r[k]  = 16'($urandom);
         model(k, e_err, e_pass, e_cyc, e_a, e_b);
         run(k, e_err, e_pass, e_cyc, e_a, e_b, 1'b0);
      end

      // Abort a run at vector 2 with an asynchronous reset between clock edges.
      mode_r[2] = 0;
      @(negedge clk);
      start_s[2] = 1'b1;
      @(posedge clk);
      #1;
      start_s[2] = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre_abort_op_b", 2, get_b(2), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_busy", 2, get_busy(2), 0);
      check("post_reset_done", 2, get_done(2), 0);
      check("post_reset_op_b", 2, get_b(2), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
